// File: rtl/canny_pkg.sv
// Shared constants and types for the Canny edge pipeline: default frame
// geometry, pixel width and the 3x3 window index map used by hysteresis.
package canny_pkg;

  localparam int DEFAULT_IMG_W = 514;
  localparam int DEFAULT_IMG_H = 514;
  localparam int DEFAULT_PIX_W = 8;

  // Row-major window positions; hysteresis input0 is wired to W_C.
  localparam int W_TL  = 0;
  localparam int W_TC  = 1;
  localparam int W_TR  = 2;
  localparam int W_ML  = 3;
  localparam int W_C   = 4;
  localparam int W_MR  = 5;
  localparam int W_BL  = 6;
  localparam int W_BC  = 7;
  localparam int W_BR  = 8;
  localparam int N_WIN = 9;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } hwb_state_t;

endpackage

// File: rtl/hyst_window_buffer_line_buffer.sv
// Circular delay line: each enabled cycle returns the word written DEPTH
// enables ago (read-before-write) and stores the new one in its place.
module line_buffer #(
  parameter int DEPTH = 514,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;

  // Old contents leave combinationally before the same slot is overwritten.
  assign dout = mem[ptr_reg];

  // Pointer advances on each enable and wraps at the last slot.
  always_comb begin
    ptr_next = ptr_reg;
    if (en) begin
      ptr_next = (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

  // Storage is deliberately not reset; row gating upstream hides stale data.
  always_ff @(posedge clk) begin
    if (en) mem[ptr_reg] <= din;
  end

endmodule

// File: rtl/hyst_window_buffer.sv
// Turns the raster stream from non-maximum suppression into interior 3x3
// windows with output-space coordinates for the hysteresis stage.
module hyst_window_buffer
  import canny_pkg::*;
#(
  parameter int IMG_W = DEFAULT_IMG_W,
  parameter int IMG_H = DEFAULT_IMG_H,
  parameter int PIX_W = DEFAULT_PIX_W
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [PIX_W-1:0]            in_data,
  output logic                        win_valid,
  output logic [N_WIN*PIX_W-1:0]      win,
  output logic [$clog2(IMG_W-2)-1:0]  out_x,
  output logic [$clog2(IMG_H-2)-1:0]  out_y,
  output logic                        frame_done,
  output logic                        err
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int OX_W  = $clog2(IMG_W - 2);
  localparam int OY_W  = $clog2(IMG_H - 2);

  hwb_state_t       state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic             err_reg, err_next;

  logic             win_valid_reg;
  logic [OX_W-1:0]  out_x_reg;
  logic [OY_W-1:0]  out_y_reg;
  logic             frame_done_reg;

  logic             accept;
  logic             last_pix;
  logic             emit;
  logic [COL_W-1:0] col_m2;
  logic [ROW_W-1:0] row_m2;
  logic [PIX_W-1:0] lb0_dout, lb1_dout;
  logic [PIX_W-1:0] new_col [3];

  // A start always takes priority, so a coincident pixel is silently dropped.
  assign accept   = (state_reg == ST_ACTIVE) && in_valid && !start;
  assign last_pix = (row_reg == ROW_W'(IMG_H - 1)) && (col_reg == COL_W'(IMG_W - 1));
  assign emit     = accept && (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));
  assign col_m2   = col_reg - COL_W'(2);
  assign row_m2   = row_reg - ROW_W'(2);

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk  (clk),
    .n_rst(n_rst),
    .en   (accept),
    .din  (in_data),
    .dout (lb0_dout)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk  (clk),
    .n_rst(n_rst),
    .en   (accept),
    .din  (lb0_dout),
    .dout (lb1_dout)
  );

  // Incoming column, top to bottom: two rows ago, one row ago, current.
  assign new_col[0] = lb1_dout;
  assign new_col[1] = lb0_dout;
  assign new_col[2] = in_data;

  // Next-state, raster counters and sticky error.
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    err_next   = err_reg;
    if (start) begin
      state_next = ST_ACTIVE;
      col_next   = '0;
      row_next   = '0;
      err_next   = 1'b0;
    end else if (state_reg == ST_ACTIVE) begin
      if (in_valid) begin
        if (col_reg == COL_W'(IMG_W - 1)) begin
          col_next = '0;
          row_next = row_reg + 1'b1;
        end else begin
          col_next = col_reg + 1'b1;
        end
        if (last_pix) state_next = ST_IDLE;
      end
    end else if (in_valid) begin
      err_next = 1'b1;
    end
  end

  // State, counters and error register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= ST_IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      err_reg   <= err_next;
    end
  end

  // Registered window strobe, output coordinates and end-of-frame pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_valid_reg  <= 1'b0;
      out_x_reg      <= '0;
      out_y_reg      <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      win_valid_reg  <= emit;
      frame_done_reg <= emit && last_pix;
      if (emit) begin
        out_x_reg <= col_m2[OX_W-1:0];
        out_y_reg <= row_m2[OY_W-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [PIX_W-1:0] row_pix_reg [3];

      // Shift this window row left by one column on every accepted pixel.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          row_pix_reg[0] <= '0;
          row_pix_reg[1] <= '0;
          row_pix_reg[2] <= '0;
        end else if (accept) begin
          row_pix_reg[0] <= row_pix_reg[1];
          row_pix_reg[1] <= row_pix_reg[2];
          row_pix_reg[2] <= new_col[gi];
        end
      end

      // Row-major packing: element 0 lands in the most significant slot.
      assign win[(N_WIN-1-(gi*3+0))*PIX_W +: PIX_W] = row_pix_reg[0];
      assign win[(N_WIN-1-(gi*3+1))*PIX_W +: PIX_W] = row_pix_reg[1];
      assign win[(N_WIN-1-(gi*3+2))*PIX_W +: PIX_W] = row_pix_reg[2];
    end
  endgenerate

  assign win_valid  = win_valid_reg;
  assign out_x      = out_x_reg;
  assign out_y      = out_y_reg;
  assign frame_done = frame_done_reg;
  assign err        = err_reg;

endmodule
